// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM-like instruction/data port arbiter.
package sram_arbiter_pkg;

    typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_idfifo.sv
// Small FIFO remembering which source owns each accepted-but-unanswered transfer.
module sram_arb_idfifo
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  src_t push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output src_t head
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    src_t          mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign full    = (count == CW'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_src;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Merges the core's inst/data SRAM-like masters onto one downstream port.
// Optional round-robin tie-break: define SRAM_ARBITER_ARB_RR_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter bit DATA_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    arb_state_t state, next_state;
    src_t       g, next_g;
    src_t       pick, grant, tie_src, head;
    logic       grant_vld, sel_data, push, pop;
    logic       fifo_full, fifo_empty;

`ifdef SRAM_ARBITER_ARB_RR_EN
    src_t last;

    assign tie_src = (last == SRC_INST) ? SRC_DATA : SRC_INST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= SRC_INST;
        else if (push)
            last <= grant;
    end
`else
    assign tie_src = DATA_FIRST ? SRC_DATA : SRC_INST;
`endif

    always_comb begin
        pick = SRC_INST;
        if (inst_req && data_req)
            pick = tie_src;
        else if (data_req)
            pick = SRC_DATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            g     <= SRC_INST;
        end else begin
            state <= next_state;
            g     <= next_g;
        end
    end

    // Gating on rst keeps every request/handshake low while reset is asserted.
    always_comb begin
        next_state = state;
        next_g     = g;
        grant_vld  = 1'b0;
        grant      = g;
        push       = 1'b0;
        if (rst && !fifo_full) begin
            case (state)
                ST_IDLE: begin
                    if (inst_req || data_req) begin
                        grant_vld = 1'b1;
                        grant     = pick;
                        if (m_addr_ok) begin
                            push = 1'b1;
                        end else begin
                            next_state = ST_HOLD;
                            next_g     = pick;
                        end
                    end
                end
                ST_HOLD: begin
                    grant_vld = 1'b1;
                    grant     = g;
                    if (m_addr_ok) begin
                        push       = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    assign sel_data = (grant == SRC_DATA);
    assign m_req    = grant_vld;
    assign m_wr     = grant_vld & (sel_data ? data_wr : inst_wr);
    assign m_size   = grant_vld ? (sel_data ? data_size : inst_size) : SIZE_BYTE;
    assign m_addr   = grant_vld ? (sel_data ? data_addr : inst_addr) : 32'd0;
    assign m_wdata  = grant_vld ? (sel_data ? data_wdata : inst_wdata) : 32'd0;

    assign inst_addr_ok = m_addr_ok & grant_vld & ~sel_data;
    assign data_addr_ok = m_addr_ok & grant_vld & sel_data;

    assign pop          = m_data_ok & rst;
    assign inst_data_ok = pop & ~fifo_empty & (head == SRC_INST);
    assign data_data_ok = pop & ~fifo_empty & (head == SRC_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    sram_arb_idfifo #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_idfifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_src (grant),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && m_data_ok && fifo_empty)
            $error("sram_arbiter: m_data_ok with no outstanding transfer");
    end
`endif

endmodule
